// File: rtl/axi_slave_core_bridge_if.sv
// AXI4 slave channels and the core-bus master signals of the AXI-to-core bridge.
// The slave modport is the bridge's view; the master modport is the AXI master plus core-bus target.
interface axi_slave_core_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]   s_axi_awid;
   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic [7:0]            s_axi_awlen;
   logic [1:0]            s_axi_awburst;
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;
   logic [31:0]           s_axi_wdata;
   logic [3:0]            s_axi_wstrb;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;
   logic [ID_WIDTH-1:0]   s_axi_bid;
   logic [1:0]            s_axi_bresp;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;
   logic [ID_WIDTH-1:0]   s_axi_arid;
   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic [7:0]            s_axi_arlen;
   logic [1:0]            s_axi_arburst;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;
   logic [ID_WIDTH-1:0]   s_axi_rid;
   logic [31:0]           s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rlast;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;
   logic [ADDR_WIDTH-1:0] mst_bus_addr;
   logic                  mst_bus_read;
   logic                  mst_bus_write;
   logic [31:0]           mst_bus_writedata;
   logic [3:0]            mst_bus_byteenable;
   logic [31:0]           mst_bus_readdata;
   logic [1:0]            mst_bus_response;
   logic                  mst_bus_waitrequest;

   modport slave (
      input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bid, s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready,
      output mst_bus_addr, mst_bus_read, mst_bus_write, mst_bus_writedata, mst_bus_byteenable,
      input  mst_bus_readdata, mst_bus_response, mst_bus_waitrequest
   );

   modport master (
      output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      output s_axi_rready,
      input  mst_bus_addr, mst_bus_read, mst_bus_write, mst_bus_writedata, mst_bus_byteenable,
      output mst_bus_readdata, mst_bus_response, mst_bus_waitrequest
   );
endinterface

// File: rtl/axi_slave_core_bridge.sv
// AXI4 slave to core-bus master bridge: one transaction at a time, one core-bus access per beat,
// round-robin between the write and read address channels.
module axi_slave_core_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   axi_slave_core_bridge_if.slave  link
);
   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_BUS,
      WR_RESP,
      RD_BUS,
      RD_DATA
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [7:0]            len_q;
   logic [7:0]            beat_cnt;
   logic                  fixed_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic [1:0]            bresp_q;
   logic [31:0]           rdata_q;
   logic [1:0]            rresp_q;
   logic                  rlast_q;
   logic                  rd_favoured;
   logic                  aw_grant;
   logic                  ar_grant;
   logic                  aw_accept;
   logic                  ar_accept;
   logic                  last_beat;

   // rd_favoured is set after a write grant, so under contention the other side wins next.
   assign aw_grant  = link.s_axi_awvalid && (!link.s_axi_arvalid || !rd_favoured);
   assign ar_grant  = link.s_axi_arvalid && (!link.s_axi_awvalid || rd_favoured);
   assign aw_accept = (state == IDLE) && !rst && aw_grant;
   assign ar_accept = (state == IDLE) && !rst && ar_grant;
   assign last_beat = (beat_cnt == len_q);
   assign addr_next = fixed_q ? addr_q : addr_q + ADDR_WIDTH'(4);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (aw_accept)      state_next = WR_DATA;
            else if (ar_accept) state_next = RD_BUS;
         end
         WR_DATA: if (link.s_axi_wvalid) state_next = WR_BUS;
         WR_BUS:  if (!link.mst_bus_waitrequest) state_next = last_beat ? WR_RESP : WR_DATA;
         WR_RESP: if (link.s_axi_bready) state_next = IDLE;
         RD_BUS:  if (!link.mst_bus_waitrequest) state_next = RD_DATA;
         RD_DATA: if (link.s_axi_rready) state_next = rlast_q ? IDLE : RD_BUS;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      link.s_axi_awready = 1'b0;
      link.s_axi_arready = 1'b0;
      link.s_axi_wready  = 1'b0;
      link.s_axi_bvalid  = 1'b0;
      link.s_axi_rvalid  = 1'b0;
      link.mst_bus_write = 1'b0;
      link.mst_bus_read  = 1'b0;
      case (state)
         IDLE: begin
            link.s_axi_awready = aw_accept;
            link.s_axi_arready = ar_accept;
         end
         WR_DATA: link.s_axi_wready  = 1'b1;
         WR_BUS:  link.mst_bus_write = 1'b1;
         WR_RESP: link.s_axi_bvalid  = 1'b1;
         RD_BUS:  link.mst_bus_read  = 1'b1;
         RD_DATA: link.s_axi_rvalid  = 1'b1;
         default: ;
      endcase
   end

   // Transaction context and per-beat payload; bus errors only accumulate, they never cut a burst short.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         beat_cnt    <= '0;
         fixed_q     <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         bresp_q     <= '0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         rlast_q     <= 1'b0;
         rd_favoured <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_accept) begin
                  id_q        <= link.s_axi_awid;
                  addr_q      <= link.s_axi_awaddr;
                  len_q       <= link.s_axi_awlen;
                  fixed_q     <= (link.s_axi_awburst == 2'b00);
                  beat_cnt    <= '0;
                  bresp_q     <= '0;
                  rd_favoured <= 1'b1;
               end else if (ar_accept) begin
                  id_q        <= link.s_axi_arid;
                  addr_q      <= link.s_axi_araddr;
                  len_q       <= link.s_axi_arlen;
                  fixed_q     <= (link.s_axi_arburst == 2'b00);
                  beat_cnt    <= '0;
                  rd_favoured <= 1'b0;
               end
            end
            WR_DATA: begin
               if (link.s_axi_wvalid) begin
                  wdata_q <= link.s_axi_wdata;
                  wstrb_q <= link.s_axi_wstrb;
               end
            end
            WR_BUS: begin
               if (!link.mst_bus_waitrequest) begin
                  if (link.mst_bus_response > bresp_q) bresp_q <= link.mst_bus_response;
                  if (!last_beat) begin
                     beat_cnt <= beat_cnt + 8'd1;
                     addr_q   <= addr_next;
                  end
               end
            end
            RD_BUS: begin
               if (!link.mst_bus_waitrequest) begin
                  rdata_q <= link.mst_bus_readdata;
                  rresp_q <= link.mst_bus_response;
                  rlast_q <= last_beat;
               end
            end
            RD_DATA: begin
               if (link.s_axi_rready && !rlast_q) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  addr_q   <= addr_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign link.s_axi_bid          = id_q;
   assign link.s_axi_bresp        = bresp_q;
   assign link.s_axi_rid          = id_q;
   assign link.s_axi_rdata        = rdata_q;
   assign link.s_axi_rresp        = rresp_q;
   assign link.s_axi_rlast        = rlast_q;
   assign link.mst_bus_addr       = addr_q;
   assign link.mst_bus_writedata  = wdata_q;
   assign link.mst_bus_byteenable = wstrb_q;
endmodule

// File: tb/tb_axi_slave_core_bridge.sv
// Directed bench for axi_slave_core_bridge: scoreboard queues filled when stimulus is issued,
// drained by a core-bus target model and B/R monitors.
module tb_axi_slave_core_bridge;
   localparam int AW = 32;
   localparam int IW = 4;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } bus_exp_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   bus_wait = 0;
   int   wait_cnt = 0;

   bus_exp_t    exp_bus[$];
   r_exp_t      exp_r[$];
   b_exp_t      exp_b[$];
   logic [31:0] rdata_plan[$];
   logic [1:0]  resp_plan[$];
   bus_exp_t    bus_e;
   r_exp_t      mon_r;
   b_exp_t      mon_b;

   axi_slave_core_bridge_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus_if ();

   axi_slave_core_bridge #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus_if)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic failNote(input string tag);
      tests++;
      fails++;
      $error("[TB] FAIL %s: observed timeout/unexpected event expected orderly completion", tag);
   endtask

   // Core-bus target: stalls each access for bus_wait cycles, then completes it and scores it.
   always @(negedge clk) begin
      if (bus_if.mst_bus_read || bus_if.mst_bus_write) begin
         if (wait_cnt < bus_wait) begin
            bus_if.mst_bus_waitrequest = 1'b1;
            wait_cnt++;
         end else begin
            bus_if.mst_bus_waitrequest = 1'b0;
            wait_cnt = 0;
            bus_if.mst_bus_response = (resp_plan.size() != 0) ? resp_plan.pop_front() : 2'b00;
            if (bus_if.mst_bus_read)
               bus_if.mst_bus_readdata = (rdata_plan.size() != 0) ? rdata_plan.pop_front() : 32'hBAD0BAD0;
            if (exp_bus.size() == 0) failNote("bus_unexpected_access");
            else begin
               bus_e = exp_bus.pop_front();
               checkOutput("bus_kind", 64'({bus_if.mst_bus_write, bus_if.mst_bus_read}), 64'({bus_e.wr, !bus_e.wr}));
               checkOutput("bus_addr", 64'(bus_if.mst_bus_addr), 64'(bus_e.addr));
               if (bus_e.wr) begin
                  checkOutput("bus_wdata", 64'(bus_if.mst_bus_writedata), 64'(bus_e.data));
                  checkOutput("bus_be", 64'(bus_if.mst_bus_byteenable), 64'(bus_e.be));
               end
            end
         end
      end else begin
         bus_if.mst_bus_waitrequest = 1'b0;
         wait_cnt = 0;
      end
   end

   always @(negedge clk) begin
      #3;
      if (bus_if.s_axi_rvalid && bus_if.s_axi_rready) begin
         if (exp_r.size() == 0) failNote("r_unexpected_beat");
         else begin
            mon_r = exp_r.pop_front();
            checkOutput("r_id", 64'(bus_if.s_axi_rid), 64'(mon_r.id));
            checkOutput("r_data", 64'(bus_if.s_axi_rdata), 64'(mon_r.data));
            checkOutput("r_resp", 64'(bus_if.s_axi_rresp), 64'(mon_r.resp));
            checkOutput("r_last", 64'(bus_if.s_axi_rlast), 64'(mon_r.last));
         end
      end
      if (bus_if.s_axi_bvalid && bus_if.s_axi_bready) begin
         if (exp_b.size() == 0) failNote("b_unexpected_response");
         else begin
            mon_b = exp_b.pop_front();
            checkOutput("b_id", 64'(bus_if.s_axi_bid), 64'(mon_b.id));
            checkOutput("b_resp", 64'(bus_if.s_axi_bresp), 64'(mon_b.resp));
         end
      end
   end

   task automatic expectTransfer(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [1:0] burst, input logic [3:0] strb,
                                 input logic [31:0] base, input int err_beat, input logic [1:0] err_resp);
      logic [31:0] a = addr;
      logic [31:0] d;
      logic [1:0]  rsp;
      logic [1:0]  worst = 2'b00;
      for (int k = 0; k <= int'(len); k++) begin
         rsp = (k == err_beat) ? err_resp : 2'b00;
         d   = base + 32'(k) * 32'h11;
         resp_plan.push_back(rsp);
         if (wr) exp_bus.push_back('{wr: 1'b1, addr: a, data: d, be: strb});
         else begin
            exp_bus.push_back('{wr: 1'b0, addr: a, data: 32'h0, be: 4'h0});
            rdata_plan.push_back(d);
            exp_r.push_back('{id: id, data: d, resp: rsp, last: (k == int'(len))});
         end
         if (rsp > worst) worst = rsp;
         if (burst != 2'b00) a = a + 32'd4;
      end
      if (wr) exp_b.push_back('{id: id, resp: worst});
   endtask

   // chan 0 = AW, 1 = AR, 2 = W; returns at the negedge after the handshake with valid dropped.
   task automatic waitHandshake(input int chan, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1;
         if ((chan == 0 && bus_if.s_axi_awready) || (chan == 1 && bus_if.s_axi_arready) ||
             (chan == 2 && bus_if.s_axi_wready)) seen = 1'b1;
         else @(negedge clk);
      end
      if (seen) @(negedge clk);
      else failNote(tag);
      if (chan == 0) bus_if.s_axi_awvalid = 1'b0;
      else if (chan == 1) bus_if.s_axi_arvalid = 1'b0;
      else bus_if.s_axi_wvalid = 1'b0;
   endtask

   task automatic setAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      bus_if.s_axi_awid = id; bus_if.s_axi_awaddr = addr; bus_if.s_axi_awlen = len;
      bus_if.s_axi_awburst = burst; bus_if.s_axi_awvalid = 1'b1;
   endtask

   task automatic setAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      bus_if.s_axi_arid = id; bus_if.s_axi_araddr = addr; bus_if.s_axi_arlen = len;
      bus_if.s_axi_arburst = burst; bus_if.s_axi_arvalid = 1'b1;
   endtask

   task automatic sendW(input logic [31:0] d, input logic [3:0] s);
      bus_if.s_axi_wdata = d; bus_if.s_axi_wstrb = s; bus_if.s_axi_wvalid = 1'b1;
      waitHandshake(2, "w_timeout");
   endtask

   task automatic applyStimulus(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [1:0] burst, input logic [3:0] strb,
                                input logic [31:0] base, input int err_beat, input logic [1:0] err_resp);
      expectTransfer(wr, id, addr, len, burst, strb, base, err_beat, err_resp);
      if (wr) begin
         setAw(id, addr, len, burst);
         waitHandshake(0, "aw_timeout");
         for (int k = 0; k <= int'(len); k++) sendW(base + 32'(k) * 32'h11, strb);
      end else begin
         setAr(id, addr, len, burst);
         waitHandshake(1, "ar_timeout");
      end
   endtask

   task automatic waitIdle(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (exp_bus.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0) return;
         @(negedge clk);
      end
      failNote(tag);
      exp_bus.delete(); exp_r.delete(); exp_b.delete(); rdata_plan.delete(); resp_plan.delete();
   endtask

   task automatic contend(input logic [31:0] waddr, input logic [31:0] raddr, input logic write_first);
      if (write_first) begin
         expectTransfer(1'b1, 4'h1, waddr, 8'd0, 2'b01, 4'hF, waddr ^ 32'h5A5A0000, -1, 2'b00);
         expectTransfer(1'b0, 4'h2, raddr, 8'd0, 2'b01, 4'h0, raddr ^ 32'hA5A50000, -1, 2'b00);
      end else begin
         expectTransfer(1'b0, 4'h2, raddr, 8'd0, 2'b01, 4'h0, raddr ^ 32'hA5A50000, -1, 2'b00);
         expectTransfer(1'b1, 4'h1, waddr, 8'd0, 2'b01, 4'hF, waddr ^ 32'h5A5A0000, -1, 2'b00);
      end
      setAw(4'h1, waddr, 8'd0, 2'b01);
      setAr(4'h2, raddr, 8'd0, 2'b01);
      #1 checkOutput("arb_grant", 64'({bus_if.s_axi_awready, bus_if.s_axi_arready}), 64'({write_first, !write_first}));
      if (write_first) begin
         waitHandshake(0, "arb_aw_timeout");
         #1 checkOutput("arb_ar_held_off", 64'(bus_if.s_axi_arready), 64'(0));
         sendW(waddr ^ 32'h5A5A0000, 4'hF);
         waitHandshake(1, "arb_ar_timeout");
      end else begin
         waitHandshake(1, "arb_ar_timeout");
         #1 checkOutput("arb_aw_held_off", 64'(bus_if.s_axi_awready), 64'(0));
         waitHandshake(0, "arb_aw_timeout");
         sendW(waddr ^ 32'h5A5A0000, 4'hF);
      end
      waitIdle("arb_idle_timeout");
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ctrl"}, 64'({bus_if.s_axi_awready, bus_if.s_axi_arready, bus_if.s_axi_wready,
                  bus_if.s_axi_bvalid, bus_if.s_axi_rvalid, bus_if.s_axi_rlast, bus_if.mst_bus_read,
                  bus_if.mst_bus_write}), 64'(0));
      checkOutput({tag, "_ids"}, 64'({bus_if.s_axi_bid, bus_if.s_axi_rid, bus_if.s_axi_bresp,
                  bus_if.s_axi_rresp, bus_if.mst_bus_byteenable}), 64'(0));
      checkOutput({tag, "_addr_wdata"}, 64'({bus_if.mst_bus_addr, bus_if.mst_bus_writedata}), 64'(0));
      checkOutput({tag, "_rdata"}, 64'(bus_if.s_axi_rdata), 64'(0));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed simulation still running expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus_if.s_axi_awid = '0; bus_if.s_axi_awaddr = '0; bus_if.s_axi_awlen = '0; bus_if.s_axi_awburst = '0;
      bus_if.s_axi_awvalid = 1'b0; bus_if.s_axi_wdata = '0; bus_if.s_axi_wstrb = '0; bus_if.s_axi_wvalid = 1'b0;
      bus_if.s_axi_bready = 1'b1; bus_if.s_axi_arid = '0; bus_if.s_axi_araddr = '0; bus_if.s_axi_arlen = '0;
      bus_if.s_axi_arburst = '0; bus_if.s_axi_arvalid = 1'b0; bus_if.s_axi_rready = 1'b1;

      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;
      @(negedge clk);

      // Reset pointer favours write; the read is served right after.
      contend(32'h0000_0600, 32'h0000_0700, 1'b1);

      // Single write, zero wait states, cycle by cycle.
      expectTransfer(1'b1, 4'h5, 32'h100, 8'd0, 2'b01, 4'hF, 32'hDEADBEEF, -1, 2'b00);
      setAw(4'h5, 32'h100, 8'd0, 2'b01);
      #1 checkOutput("sw_awready_c0", 64'(bus_if.s_axi_awready), 64'(1));
      @(negedge clk);
      bus_if.s_axi_awvalid = 1'b0;
      bus_if.s_axi_wdata = 32'hDEADBEEF; bus_if.s_axi_wstrb = 4'hF; bus_if.s_axi_wvalid = 1'b1;
      #1 checkOutput("sw_wready_c1", 64'({bus_if.s_axi_wready, bus_if.mst_bus_write, bus_if.s_axi_awready}), 64'(3'b100));
      @(negedge clk);
      bus_if.s_axi_wvalid = 1'b0;
      #1 checkOutput("sw_bus_write_c2", 64'({bus_if.mst_bus_write, bus_if.mst_bus_byteenable, bus_if.mst_bus_addr}),
                     64'({1'b1, 4'hF, 32'h100}));
      checkOutput("sw_bus_data_c2", 64'({bus_if.s_axi_bvalid, bus_if.mst_bus_writedata}), 64'({1'b0, 32'hDEADBEEF}));
      @(negedge clk);
      #1 checkOutput("sw_bvalid_c3", 64'({bus_if.s_axi_bvalid, bus_if.s_axi_bid, bus_if.s_axi_bresp}),
                     64'({1'b1, 4'h5, 2'b00}));
      waitIdle("sw_idle_timeout");

      // INCR read burst with two wait states per beat and a DECERR on beat 1.
      bus_wait = 2;
      applyStimulus(1'b0, 4'h3, 32'h200, 8'd3, 2'b01, 4'h0, 32'h11, 1, 2'b11);
      waitIdle("incr_rd_timeout");
      bus_wait = 0;

      // FIXED write burst, SLVERR on the last beat folds into one bresp.
      applyStimulus(1'b1, 4'hA, 32'h40, 8'd2, 2'b00, 4'h3, 32'hA000_0000, 2, 2'b10);
      waitIdle("fixed_wr_timeout");

      // Last served was write, so a contended pair goes to the read first.
      contend(32'h0000_0A00, 32'h0000_0B00, 1'b0);

      // R backpressure on beat 0 of a two-beat read.
      bus_if.s_axi_rready = 1'b0;
      applyStimulus(1'b0, 4'h7, 32'h500, 8'd1, 2'b01, 4'h0, 32'hC0DE0000, -1, 2'b00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 checkOutput("bp_r_stable", 64'({bus_if.s_axi_rvalid, bus_if.s_axi_rlast, bus_if.mst_bus_read, bus_if.s_axi_rdata}),
                        64'({1'b1, 1'b0, 1'b0, 32'hC0DE0000}));
      end
      @(negedge clk);
      bus_if.s_axi_rready = 1'b1;
      waitIdle("bp_rd_timeout");

      // Two back-to-back contentions both go to the write after a read was served last.
      contend(32'h0000_0C00, 32'h0000_0D00, 1'b1);
      contend(32'h0000_0E00, 32'h0000_0F00, 1'b1);

      // Reset while a write burst is stalled on the bus.
      bus_wait = 5;
      setAw(4'h9, 32'h800, 8'd3, 2'b01);
      waitHandshake(0, "rst_aw_timeout");
      sendW(32'h12345678, 4'hF);
      #1 checkOutput("rst_pre_wr_bus", 64'(bus_if.mst_bus_write), 64'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkResetValues("midrst");
      rst = 1'b0;
      bus_wait = 0;
      @(negedge clk);

      expectTransfer(1'b0, 4'h6, 32'h900, 8'd0, 2'b01, 4'h0, 32'h900D0006, -1, 2'b00);
      setAr(4'h6, 32'h900, 8'd0, 2'b01);
      #1 checkOutput("post_rst_arready_c0", 64'({bus_if.s_axi_arready, bus_if.s_axi_awready}), 64'(2'b10));
      @(negedge clk);
      bus_if.s_axi_arvalid = 1'b0;
      #1 checkOutput("post_rst_bus_read_c1", 64'({bus_if.mst_bus_read, bus_if.mst_bus_addr}), 64'({1'b1, 32'h900}));
      @(negedge clk);
      #1 checkOutput("post_rst_rvalid_c2", 64'({bus_if.s_axi_rvalid, bus_if.s_axi_rlast, bus_if.s_axi_rdata}),
                     64'({1'b1, 1'b1, 32'h900D0006}));
      waitIdle("post_rst_rd_timeout");

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(exp_bus.size() + exp_r.size() + exp_b.size() +
                  rdata_plan.size() + resp_plan.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
